// File: rtl/fifo_width_conv.sv
// Wide-write, narrow-read FIFO: each stored word pops as 2^RATIO_LOG2 sub-words.
// Define FIFO_WC_ERR_FLAGS_EN to build the sticky overflow/underflow flags.
module fifo_width_conv #(
  parameter int W_DATA_WIDTH = 8,
  parameter int RATIO_LOG2   = 1,
  parameter int ADDR_WIDTH   = 2,
  parameter bit MSB_FIRST    = 1'b0
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  wr,
  input  logic [W_DATA_WIDTH-1:0]               w_data,
  input  logic                                  rd,
  output logic [(W_DATA_WIDTH>>RATIO_LOG2)-1:0] r_data,
  output logic                                  empty,
  output logic                                  full,
  output logic [ADDR_WIDTH+RATIO_LOG2:0]        level,
  output logic                                  err_ovf,
  output logic                                  err_udf
);

  localparam int R_DATA_WIDTH = W_DATA_WIDTH >> RATIO_LOG2;
  localparam int NSUB  = 1 << RATIO_LOG2;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int LW    = ADDR_WIDTH + RATIO_LOG2 + 1;

  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]           rd_word;
  logic [LW-1:0]           wr_sub;
  logic [LW-1:0]           sub_idx;
  logic [LW-1:0]           sel;
  logic [W_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [W_DATA_WIDTH-1:0] head;
  logic                    wr_ok;
  logic                    rd_ok;

  // Write pointer scaled to sub-word units so both sides compare directly.
  assign wr_sub  = LW'(wr_ptr_q) << RATIO_LOG2;
  assign rd_word = rd_ptr_q[LW-1:RATIO_LOG2];
  assign sub_idx = rd_ptr_q & LW'(NSUB - 1);
  assign sel     = MSB_FIRST ? (LW'(NSUB - 1) - sub_idx) : sub_idx;

  assign empty = (wr_sub == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_word) == (PW'(1) << ADDR_WIDTH));
  assign level = wr_sub - rd_ptr_q;

  assign wr_ok = wr & ~full;
  assign rd_ok = rd & ~empty;

  assign wr_ptr_d = wr_ptr_q + PW'(wr_ok);
  assign rd_ptr_d = rd_ptr_q + LW'(rd_ok);

  assign head = mem_q[rd_word[ADDR_WIDTH-1:0]];

  always_comb begin
    r_data = '0;
    if (!empty) begin
      for (int i = 0; i < NSUB; i++) begin
        if (sel == LW'(i)) begin
          r_data = head[i*R_DATA_WIDTH +: R_DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= w_data;
    end
  end

`ifdef FIFO_WC_ERR_FLAGS_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;

  assign err_ovf_d = err_ovf_q | (wr & full);
  assign err_udf_d = err_udf_q | (rd & empty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_width_conv.sv
// Bench for fifo_width_conv: default 8->4 LSB-first and a 16->4 MSB-first copy,
// both compared against sub-word queue models.
module tb_fifo_width_conv;

`ifdef FIFO_WC_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;

  logic       wr0 = 1'b0, rd0 = 1'b0;
  logic [7:0] wd0 = '0;
  logic [3:0] rdata0;
  logic       empty0, full0, ovf0, udf0;
  logic [3:0] lvl0;

  logic        wr1 = 1'b0, rd1 = 1'b0;
  logic [15:0] wd1 = '0;
  logic [3:0]  rdata1;
  logic        empty1, full1, ovf1, udf1;
  logic [4:0]  lvl1;

  fifo_width_conv dut0 (
    .clk(clk), .reset(reset), .wr(wr0), .w_data(wd0), .rd(rd0),
    .r_data(rdata0), .empty(empty0), .full(full0), .level(lvl0),
    .err_ovf(ovf0), .err_udf(udf0)
  );

  fifo_width_conv #(
    .W_DATA_WIDTH(16), .RATIO_LOG2(2), .ADDR_WIDTH(2), .MSB_FIRST(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .wr(wr1), .w_data(wd1), .rd(rd1),
    .r_data(rdata1), .empty(empty1), .full(full1), .level(lvl1),
    .err_ovf(ovf1), .err_udf(udf1)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  bit eo0, eu0, eo1, eu1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Occupied word slots: a partly read word still holds its slot.
  function automatic int words(int n, int nsub);
    return (n + nsub - 1) / nsub;
  endfunction

  task automatic check0(string tag);
    chk({tag, "/empty0"}, 32'(empty0), 32'(q0.size() == 0));
    chk({tag, "/full0"}, 32'(full0), 32'(words(q0.size(), 2) == 4));
    chk({tag, "/level0"}, 32'(lvl0), 32'(q0.size()));
    chk({tag, "/rdata0"}, 32'(rdata0), q0.size() ? 32'(q0[0]) : 32'h0);
    chk({tag, "/ovf0"}, 32'(ovf0), 32'(eo0));
    chk({tag, "/udf0"}, 32'(udf0), 32'(eu0));
  endtask

  task automatic check1(string tag);
    chk({tag, "/empty1"}, 32'(empty1), 32'(q1.size() == 0));
    chk({tag, "/full1"}, 32'(full1), 32'(words(q1.size(), 4) == 4));
    chk({tag, "/level1"}, 32'(lvl1), 32'(q1.size()));
    chk({tag, "/rdata1"}, 32'(rdata1), q1.size() ? 32'(q1[0]) : 32'h0);
    chk({tag, "/ovf1"}, 32'(ovf1), 32'(eo1));
    chk({tag, "/udf1"}, 32'(udf1), 32'(eu1));
  endtask

  task automatic cyc0(bit w, logic [7:0] d, bit r, string tag);
    bit fm, em;
    fm = (words(q0.size(), 2) == 4);
    em = (q0.size() == 0);
    wr0 = w; wd0 = d; rd0 = r;
    @(posedge clk);
    #1;
    wr0 = 1'b0; rd0 = 1'b0;
    if (r && !em) void'(q0.pop_front());
    if (w && !fm) begin
      q0.push_back(d[3:0]);
      q0.push_back(d[7:4]);
    end
    if (ERR_EN) begin
      eo0 |= w && fm;
      eu0 |= r && em;
    end
    check0(tag);
  endtask

  task automatic cyc1(bit w, logic [15:0] d, bit r, string tag);
    bit fm, em;
    fm = (words(q1.size(), 4) == 4);
    em = (q1.size() == 0);
    wr1 = w; wd1 = d; rd1 = r;
    @(posedge clk);
    #1;
    wr1 = 1'b0; rd1 = 1'b0;
    if (r && !em) void'(q1.pop_front());
    if (w && !fm) begin
      q1.push_back(d[15:12]);
      q1.push_back(d[11:8]);
      q1.push_back(d[7:4]);
      q1.push_back(d[3:0]);
    end
    if (ERR_EN) begin
      eo1 |= w && fm;
      eu1 |= r && em;
    end
    check1(tag);
  endtask

  task automatic clear_models();
    q0.delete(); q1.delete();
    eo0 = 0; eu0 = 0; eo1 = 0; eu1 = 0;
  endtask

  initial begin
    logic [7:0] b;
    clear_models();
    @(posedge clk);
    #1;
    check0("reset");
    check1("reset");
    reset = 1'b0;

    cyc0(1, 8'h31, 0, "basic_wr");
    chk("basic_lvl2", 32'(lvl0), 32'd2);
    cyc0(0, 8'h00, 1, "basic_rd1");
    chk("basic_nib3", 32'(rdata0), 32'h3);
    chk("basic_lvl1", 32'(lvl0), 32'd1);
    cyc0(0, 8'h00, 1, "basic_rd2");
    chk("basic_empty", 32'(empty0), 32'd1);

    cyc0(1, 8'h01, 0, "fill1");
    cyc0(1, 8'h03, 0, "fill2");
    cyc0(1, 8'h80, 0, "fill3");
    cyc0(1, 8'h30, 0, "fill4");
    chk("fill_full", 32'(full0), 32'd1);
    chk("fill_lvl8", 32'(lvl0), 32'd8);
    cyc0(1, 8'h00, 0, "ovf");
    chk("ovf_lvl8", 32'(lvl0), 32'd8);
    chk("ovf_flag", 32'(ovf0), 32'(ERR_EN));

    cyc0(0, 8'h00, 1, "part1");
    chk("part_full", 32'(full0), 32'd1);
    chk("part_lvl7", 32'(lvl0), 32'd7);
    cyc0(0, 8'h00, 1, "part2");
    chk("part_nfull", 32'(full0), 32'd0);
    chk("part_lvl6", 32'(lvl0), 32'd6);

    cyc0(0, 8'h00, 1, "to4a");
    cyc0(0, 8'h00, 1, "to4b");
    chk("sim_lvl4", 32'(lvl0), 32'd4);
    b = 8'h40;
    for (int i = 0; i < 20; i++) begin
      cyc0(1, b, 1, "simul");
      b++;
    end

    for (int i = 0; i < 300; i++) begin
      cyc0(1'($urandom_range(0, 1)), 8'($urandom),
           1'($urandom_range(0, 1)), "rand0");
    end

    for (int i = 0; i < 20 && q0.size() > 0; i++) cyc0(0, 8'h00, 1, "drain");
    chk("drained", 32'(empty0), 32'd1);

    cyc1(1, 16'hABCD, 0, "msb_wr");
    chk("msb_A", 32'(rdata1), 32'hA);
    cyc1(0, 16'h0, 1, "msb_rd1");
    chk("msb_B", 32'(rdata1), 32'hB);
    cyc1(0, 16'h0, 1, "msb_rd2");
    chk("msb_C", 32'(rdata1), 32'hC);
    cyc1(0, 16'h0, 1, "msb_rd3");
    chk("msb_D", 32'(rdata1), 32'hD);
    cyc1(0, 16'h0, 1, "msb_rd4");
    for (int i = 0; i < 120; i++) begin
      cyc1(1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 1)), "rand1");
    end

    cyc0(1, 8'h5A, 0, "lv5a");
    cyc0(1, 8'hC3, 0, "lv5b");
    cyc0(1, 8'h96, 0, "lv5c");
    cyc0(0, 8'h00, 1, "lv5d");
    chk("pre_rst_lvl5", 32'(lvl0), 32'd5);
    #3;
    reset = 1'b1;
    #1;
    clear_models();
    check0("async_rst");
    check1("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc0(0, 8'h00, 1, "udf");
    chk("udf_lvl0", 32'(lvl0), 32'd0);
    chk("udf_flag", 32'(udf0), 32'(ERR_EN));
    cyc0(1, 8'hE7, 0, "post_rst_wr");
    chk("post_rst_nib", 32'(rdata0), 32'h7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
